// File: rtl/xosera_pkg.sv
// Shared types and constants for the plot writer: FSM states, VRAM
// write-request record and the 4bpp pixel-to-nibble mask helper.
package xosera_pkg;

  localparam int DEF_CORDW    = 10;
  localparam int DEF_ADDRW    = 16;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } plot_state_t;

  typedef struct packed {
    logic [DEF_ADDRW-1:0]    addr;
    logic [PIX_PER_WORD-1:0] mask;
    logic [15:0]             data;
  } vram_wreq_t;

  // Leftmost pixel of a word lives in the top nibble.
  function automatic logic [PIX_PER_WORD-1:0] pix_mask(input logic [1:0] sub);
    logic [PIX_PER_WORD-1:0] msb;
    msb = {1'b1, {(PIX_PER_WORD-1){1'b0}}};
    return msb >> sub;
  endfunction

endpackage

// File: rtl/draw_plot_addr.sv
// S2 of the plot pipeline: registered VRAM word address and nibble mask for
// one in-window pixel. Kept separate so the y*pitch multiply can be retimed.
module draw_plot_addr
  import xosera_pkg::*;
#(
  parameter int CORDW = DEF_CORDW,
  parameter int ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [CORDW-2:0] x_i,
  input  logic [CORDW-2:0] y_i,
  input  logic [ADDRW-1:0] base_i,
  input  logic [7:0]       words_i,
  output logic             valid_o,
  output logic [ADDRW-1:0] addr_o,
  output logic [3:0]       mask_o
);

  localparam int PW = CORDW - 1 + 8;

  logic [PW-1:0]    row_off;
  logic             valid_q, valid_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [3:0]       mask_q, mask_d;

  always_comb begin
    row_off = PW'(y_i) * PW'(words_i);
    valid_d = load_i | (valid_q & ~adv_i);
    addr_d  = addr_q;
    mask_d  = mask_q;
    if (load_i) begin
      // Sum wraps modulo 2^ADDRW; the rasteriser may legally cross the top.
      addr_d = base_i + ADDRW'(row_off) + ADDRW'(x_i[CORDW-2:2]);
      mask_d = pix_mask(x_i[1:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign mask_o  = mask_q;

endmodule

// File: rtl/draw_plot_writer.sv
// Pixel-to-VRAM write stage: clip, address, coalesce same-word pixels into
// one masked write, and back-pressure the rasteriser via ena_draw_o.
//   state | meaning
//   IDLE  | waiting for start_i, configuration latched on start
//   RUN   | accepting pixels until line_done_i
//   FLUSH | draining S1/S2/coalesce/output, done_o when all empty
module draw_plot_writer
  import xosera_pkg::*;
#(
  parameter int CORDW = DEF_CORDW,
  parameter int ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [ADDRW-1:0] base_i,
  input  logic [7:0]       words_i,
  input  logic [CORDW-1:0] clip_w_i,
  input  logic [CORDW-1:0] clip_h_i,
  input  logic [3:0]       color_i,
  input  logic             pix_valid_i,
  input  logic [CORDW-1:0] pix_x_i,
  input  logic [CORDW-1:0] pix_y_i,
  input  logic             line_done_i,
  output logic             ena_draw_o,
  output logic             vram_wr_o,
  output logic [ADDRW-1:0] vram_addr_o,
  output logic [3:0]       vram_mask_o,
  output logic [15:0]      vram_data_o,
  input  logic             vram_ack_i,
  output logic             busy_o,
  output logic             done_o
);

  plot_state_t      state_q, state_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [7:0]       words_q, words_d;
  logic [CORDW-1:0] clip_w_q, clip_w_d, clip_h_q, clip_h_d;
  logic [3:0]       color_q, color_d;

  logic             s1_v_q, s1_v_d;
  logic [CORDW-2:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

  logic             cb_v_q, cb_v_d;
  logic [ADDRW-1:0] cb_addr_q, cb_addr_d;
  logic [3:0]       cb_mask_q, cb_mask_d;

  logic             out_v_q, out_v_d;
  vram_wreq_t       out_q, out_d;

  logic             s2_v;
  logic [ADDRW-1:0] s2_addr;
  logic [3:0]       s2_mask;

  logic out_free, cb_hit, s2_adv, s2_fire, s1_adv, s1_fire;
  logic pix_acc, in_win, pipe_empty, cb_flush, cb_to_out, all_empty;

  draw_plot_addr #(
    .CORDW(CORDW),
    .ADDRW(ADDRW)
  ) u_addr (
    .clk      (clk),
    .reset_n_i(reset_n_i),
    .load_i   (s1_fire),
    .adv_i    (s2_adv),
    .x_i      (s1_x_q),
    .y_i      (s1_y_q),
    .base_i   (base_q),
    .words_i  (words_q),
    .valid_o  (s2_v),
    .addr_o   (s2_addr),
    .mask_o   (s2_mask)
  );

  // Handshake chain, evaluated back to front from the output register.
  always_comb begin
    out_free   = !out_v_q || vram_ack_i;
    cb_hit     = cb_v_q && (s2_addr == cb_addr_q);
    s2_adv     = !cb_v_q || cb_hit || out_free;
    s2_fire    = s2_v && s2_adv;
    s1_adv     = !s2_v || s2_adv;
    s1_fire    = s1_v_q && s1_adv;
    ena_draw_o = (state_q == RUN) && (!s1_v_q || s1_adv);
    pix_acc    = pix_valid_i && ena_draw_o;
    in_win     = !pix_x_i[CORDW-1] && ($signed(pix_x_i) < $signed(clip_w_q)) &&
                 !pix_y_i[CORDW-1] && ($signed(pix_y_i) < $signed(clip_h_q));
    pipe_empty = !s1_v_q && !s2_v;
    cb_flush   = (state_q == FLUSH) && pipe_empty && cb_v_q && out_free;
    cb_to_out  = (s2_fire && cb_v_q && !cb_hit) || cb_flush;
    all_empty  = pipe_empty && !cb_v_q && !out_v_q;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    words_d  = words_q;
    clip_w_d = clip_w_q;
    clip_h_d = clip_h_q;
    color_d  = color_q;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          base_d   = base_i;
          words_d  = words_i;
          clip_w_d = clip_w_i;
          clip_h_d = clip_h_i;
          color_d  = color_i;
        end
      end
      RUN: begin
        if (line_done_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (all_empty) begin
          state_d = IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_v_d = s1_v_q && !s1_adv;
    s1_x_d = s1_x_q;
    s1_y_d = s1_y_q;
    // Clipped pixels are consumed here and never occupy S1.
    if (pix_acc && in_win) begin
      s1_v_d = 1'b1;
      s1_x_d = pix_x_i[CORDW-2:0];
      s1_y_d = pix_y_i[CORDW-2:0];
    end

    cb_v_d    = cb_v_q;
    cb_addr_d = cb_addr_q;
    cb_mask_d = cb_mask_q;
    if (s2_fire) begin
      if (cb_hit) begin
        cb_mask_d = cb_mask_q | s2_mask;
      end else begin
        cb_v_d    = 1'b1;
        cb_addr_d = s2_addr;
        cb_mask_d = s2_mask;
      end
    end else if (cb_flush) begin
      cb_v_d = 1'b0;
    end

    out_v_d = out_v_q;
    out_d   = out_q;
    if (cb_to_out) begin
      out_v_d    = 1'b1;
      out_d.addr = cb_addr_q;
      out_d.mask = cb_mask_q;
      out_d.data = {4{color_q}};
    end else if (vram_ack_i) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      words_q   <= '0;
      clip_w_q  <= '0;
      clip_h_q  <= '0;
      color_q   <= '0;
      s1_v_q    <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      cb_v_q    <= 1'b0;
      cb_addr_q <= '0;
      cb_mask_q <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      words_q   <= words_d;
      clip_w_q  <= clip_w_d;
      clip_h_q  <= clip_h_d;
      color_q   <= color_d;
      s1_v_q    <= s1_v_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      cb_v_q    <= cb_v_d;
      cb_addr_q <= cb_addr_d;
      cb_mask_q <= cb_mask_d;
      out_v_q   <= out_v_d;
      out_q     <= out_d;
    end
  end

  assign vram_wr_o   = out_v_q;
  assign vram_addr_o = out_q.addr;
  assign vram_mask_o = out_q.mask;
  assign vram_data_o = out_q.data;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_draw_plot_writer.sv
// Scoreboard bench for draw_plot_writer: tests push expected writes, a
// monitor pops and compares on every acked VRAM write.
module tb_draw_plot_writer;
  import xosera_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [7:0]  words = '0;
  logic [9:0]  clip_w = '0, clip_h = '0;
  logic [3:0]  color = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        line_done = 1'b0;
  logic        ena, wr, busy, done;
  logic [15:0] addr, data;
  logic [3:0]  mask;
  logic        ack = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic ena_low_seen = 1'b0;
  logic hold_v = 1'b0;
  logic [15:0] hold_a = '0;
  logic [3:0]  hold_m = '0;
  vram_wreq_t exp_q[$];
  int px[$];
  int py[$];

  draw_plot_writer dut (
    .clk        (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .base_i     (base),
    .words_i    (words),
    .clip_w_i   (clip_w),
    .clip_h_i   (clip_h),
    .color_i    (color),
    .pix_valid_i(pix_valid),
    .pix_x_i    (pix_x),
    .pix_y_i    (pix_y),
    .line_done_i(line_done),
    .ena_draw_o (ena),
    .vram_wr_o  (wr),
    .vram_addr_o(addr),
    .vram_mask_o(mask),
    .vram_data_o(data),
    .vram_ack_i (ack),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic void push_exp(input logic [15:0] a, input logic [3:0] m, input logic [3:0] c);
    vram_wreq_t e;
    e.addr = a;
    e.mask = m;
    e.data = {4{c}};
    exp_q.push_back(e);
  endfunction

  // Ack driver: low while stall_cnt runs down, else always accepting.
  initial forever begin
    @(negedge clk);
    if (stall_cnt > 0) begin
      ack = 1'b0;
      stall_cnt--;
    end else begin
      ack = 1'b1;
    end
  end

  // Monitor: sampled just before each rising edge.
  initial forever begin
    vram_wreq_t e;
    @(negedge clk);
    #4;
    if (wr && hold_v) begin
      check("addr_stable", addr, hold_a);
      check("mask_stable", mask, hold_m);
    end
    hold_v = wr && !ack;
    hold_a = addr;
    hold_m = mask;
    if (wr && ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h mask %b, no write expected", addr, mask);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", addr, e.addr);
        check("wr_mask", mask, e.mask);
        check("wr_data", data, e.data);
      end
    end
    if (done) done_cnt++;
  end

  task automatic start_line(input logic [15:0] b, input logic [7:0] w, input logic [9:0] cw,
                            input logic [9:0] ch, input logic [3:0] c);
    @(negedge clk);
    base = b; words = w; clip_w = cw; clip_h = ch; color = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the design must use the latched copy.
    base = 16'hDEAD; words = 8'd0; clip_w = 10'd0; clip_h = 10'd0; color = 4'h0;
    done_cnt = 0;
    check("busy_after_start", busy, 1);
  endtask

  // done_mode: 0 = separate line_done pulse, 1 = with last pixel, 2 = none
  task automatic send_line(input int done_mode);
    for (int i = 0; i < px.size(); i++) begin
      int waits;
      logic acc;
      waits = 0;
      acc = 1'b0;
      @(negedge clk);
      pix_valid = 1'b1;
      pix_x = 10'(px[i]);
      pix_y = 10'(py[i]);
      while (!acc) begin
        #4;
        if (ena) begin
          acc = 1'b1;
          if (i == px.size() - 1 && done_mode == 1) line_done = 1'b1;
        end else begin
          ena_low_seen = 1'b1;
          waits++;
          if (waits > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL pix_accept_timeout: pixel %0d ena=%b expected 1", i, ena);
            acc = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    line_done = 1'b0;
    if (done_mode == 0) begin
      line_done = 1'b1;
      @(negedge clk);
      line_done = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (done_cnt == 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ena"}, ena, 0);
    check({name, "_wr"}, wr, 0);
    check({name, "_addr"}, addr, 0);
    check({name, "_mask"}, mask, 0);
    check({name, "_data"}, data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #1 reset_n = 1'b0;
    #10 check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Horizontal run
    push_exp(16'h1000, 4'hF, 4'hA);
    push_exp(16'h1001, 4'hF, 4'hA);
    start_line(16'h1000, 8'd40, 10'd320, 10'd240, 4'hA);
    px = {0, 1, 2, 3, 4, 5, 6, 7};
    py = {0, 0, 0, 0, 0, 0, 0, 0};
    send_line(0);
    wait_done("horiz");

    // Vertical run, line_done together with the last pixel
    push_exp(16'h1001, 4'b0100, 4'h3);
    push_exp(16'h1029, 4'b0100, 4'h3);
    push_exp(16'h1051, 4'b0100, 4'h3);
    start_line(16'h1000, 8'd40, 10'd320, 10'd240, 4'h3);
    px = {5, 5, 5};
    py = {0, 1, 2};
    send_line(1);
    wait_done("vert");

    // Clipping on both axes
    push_exp(16'h0200, 4'b1100, 4'h5);
    start_line(16'h0200, 8'd40, 10'd320, 10'd240, 4'h5);
    px = {-2, -1, 0, 1, 320, 2, 3};
    py = {0, 0, 0, 0, 0, 240, -1};
    send_line(0);
    wait_done("clip");

    // Fully clipped line: done one cycle after FLUSH entry
    start_line(16'h0400, 8'd40, 10'd320, 10'd240, 4'h6);
    px = {-1};
    py = {0};
    send_line(1);
    #4 check("clipped_done_latency", done, 1);
    wait_done("clipped");

    // Back-pressure on an 8-pixel diagonal
    for (int i = 0; i < 8; i++)
      push_exp(16'h2000 + 16'(i * 40) + 16'(i / 4), 4'b1000 >> (i % 4), 4'h7);
    start_line(16'h2000, 8'd40, 10'd320, 10'd240, 4'h7);
    ena_low_seen = 1'b0;
    @(posedge clk);
    stall_cnt = 10;
    px = {0, 1, 2, 3, 4, 5, 6, 7};
    py = {0, 1, 2, 3, 4, 5, 6, 7};
    send_line(0);
    wait_done("diag");
    check("diag_ena_dropped", ena_low_seen, 1);

    // Reset mid-line with a write pending
    start_line(16'h3000, 8'd40, 10'd320, 10'd240, 4'hB);
    @(posedge clk);
    stall_cnt = 1000;
    px = {0, 0};
    py = {0, 1};
    send_line(2);
    c = 0;
    while (!wr && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("wr_before_reset", wr, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    stall_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Address wrap after reset
    push_exp(16'h0000, 4'b1000, 4'h9);
    start_line(16'hFFFF, 8'd40, 10'd320, 10'd240, 4'h9);
    px = {4};
    py = {0};
    send_line(0);
    wait_done("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
